// File: rtl/rs_dispatch_issue_ctrl.sv
// rtl/rs_dispatch_issue_ctrl.sv - reservation-station dispatch allocation and round-robin issue control
module rs_dispatch_issue_ctrl #(
    parameter int RS_SIZE = 8,
    parameter int IDX_W   = $clog2(RS_SIZE),
    parameter int CNT_W   = $clog2(RS_SIZE + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               dispatch_valid,
    output logic               dispatch_stall,
    output logic [RS_SIZE-1:0] entry_wr_en,
    input  logic [RS_SIZE-1:0] entry_ready,
    input  logic               fu_avail,
    output logic               issue_valid,
    output logic [IDX_W-1:0]   issue_idx,
    output logic [RS_SIZE-1:0] entry_clear,
    input  logic               squash,
    output logic [CNT_W-1:0]   free_count
);

    logic [RS_SIZE-1:0] occ;
    logic [RS_SIZE-1:0] occ_next;
    logic [RS_SIZE-1:0] cand;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_next;
    logic [IDX_W-1:0]   probe;
    logic               alloc_found;
    logic [IDX_W-1:0]   alloc_idx;
    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic [CNT_W-1:0]   busy_next;

    // Lowest-index free entry; scanning downward leaves the lowest hit last.
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int k = RS_SIZE - 1; k >= 0; k--) begin
            if (!occ[k]) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(k);
            end
        end
    end

    // First ready-and-occupied entry at or after rr_ptr; index arithmetic wraps naturally.
    always_comb begin
        cand        = entry_ready & occ;
        grant_found = 1'b0;
        grant_idx   = '0;
        probe       = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            probe = rr_ptr + IDX_W'(i);
            if (cand[probe]) begin
                grant_found = 1'b1;
                grant_idx   = probe;
            end
        end
    end

    // Dispatch/issue/squash outputs; squash overrides both dispatch and issue.
    always_comb begin
        dispatch_stall = 1'b1;
        entry_wr_en    = '0;
        entry_clear    = '0;
        issue_valid    = 1'b0;
        issue_idx      = '0;
        rr_next        = rr_ptr;
        if (!reset) begin
            dispatch_stall = squash | (&occ);
            if (squash) begin
                entry_clear = '1;
                rr_next     = '0;
            end else begin
                if (dispatch_valid && !dispatch_stall && alloc_found) begin
                    entry_wr_en[alloc_idx] = 1'b1;
                end
                if (fu_avail && grant_found) begin
                    issue_valid            = 1'b1;
                    issue_idx              = grant_idx;
                    entry_clear[grant_idx] = 1'b1;
                    rr_next                = grant_idx + IDX_W'(1);
                end
            end
        end
    end

    // Next occupancy and its population count for the registered free_count.
    always_comb begin
        occ_next  = (occ & ~entry_clear) | entry_wr_en;
        busy_next = '0;
        for (int k = 0; k < RS_SIZE; k++) begin
            busy_next = busy_next + CNT_W'(occ_next[k]);
        end
    end

    // State registers: occupancy mirror, round-robin pointer, free count.
    always_ff @(posedge clock) begin
        if (reset) begin
            occ        <= '0;
            rr_ptr     <= '0;
            free_count <= CNT_W'(RS_SIZE);
        end else begin
            occ        <= occ_next;
            rr_ptr     <= rr_next;
            free_count <= CNT_W'(RS_SIZE) - busy_next;
        end
    end

endmodule

// File: tb/tb_rs_dispatch_issue_ctrl.sv
// tb/tb_rs_dispatch_issue_ctrl.sv - directed self-checking bench for rs_dispatch_issue_ctrl
module tb_rs_dispatch_issue_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       dispatch_valid;
    logic       dispatch_stall;
    logic [7:0] entry_wr_en;
    logic [7:0] entry_ready;
    logic       fu_avail;
    logic       issue_valid;
    logic [2:0] issue_idx;
    logic [7:0] entry_clear;
    logic       squash;
    logic [3:0] free_count;

    int checks = 0;
    int errors = 0;

    rs_dispatch_issue_ctrl #(.RS_SIZE(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .dispatch_valid (dispatch_valid),
        .dispatch_stall (dispatch_stall),
        .entry_wr_en    (entry_wr_en),
        .entry_ready    (entry_ready),
        .fu_avail       (fu_avail),
        .issue_valid    (issue_valid),
        .issue_idx      (issue_idx),
        .entry_clear    (entry_clear),
        .squash         (squash),
        .free_count     (free_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge, then check outputs mid-low-phase.
    task automatic vec(input string tag, input logic rst, input logic dv, input logic [7:0] rdy,
                       input logic fu, input logic sq, input logic [7:0] e_wr, input logic e_stall,
                       input logic e_iv, input logic [2:0] e_idx, input logic [7:0] e_clr,
                       input logic [3:0] e_fc);
        @(negedge clock);
        reset          = rst;
        dispatch_valid = dv;
        entry_ready    = rdy;
        fu_avail       = fu;
        squash         = sq;
        #2;
        chk({tag, ".wr_en"}, 32'(entry_wr_en), 32'(e_wr));
        chk({tag, ".stall"}, 32'(dispatch_stall), 32'(e_stall));
        chk({tag, ".issue_valid"}, 32'(issue_valid), 32'(e_iv));
        chk({tag, ".issue_idx"}, 32'(issue_idx), 32'(e_idx));
        chk({tag, ".clear"}, 32'(entry_clear), 32'(e_clr));
        chk({tag, ".free_count"}, 32'(free_count), 32'(e_fc));
    endtask

    // Dispatch into an empty array for n cycles with no issue.
    task automatic fill(input string tag, input int n);
        for (int i = 0; i < n; i++)
            vec($sformatf("%s%0d", tag, i), 0, 1, 8'h00, 0, 0, 8'(1 << i), 0, 0, 0, 8'h00, 4'(8 - i));
    endtask

    int skip_idx[6] = '{0, 1, 4, 5, 6, 7};

    initial begin
        reset = 1'b1; dispatch_valid = 1'b0; entry_ready = 8'h00; fu_avail = 1'b0; squash = 1'b0;
        @(posedge clock);
        // Reset forces all combinational outputs even with live inputs.
        vec("rst", 1, 1, 8'hFF, 1, 0, 8'h00, 1, 0, 0, 8'h00, 4'd8);

        // Fill from empty, then the ninth dispatch stalls.
        fill("fill_a", 8);
        vec("fill_a_full", 0, 1, 8'h00, 0, 0, 8'h00, 1, 0, 0, 8'h00, 4'd0);

        // Round-robin skips non-ready entries: 0,1,4,5,6,7 leaves occ=0x0C, rr_ptr=0.
        for (int i = 0; i < 6; i++)
            vec($sformatf("rr_skip%0d", i), 0, 0, 8'hF3, 1, 0, 8'h00, (i == 0), 1,
                3'(skip_idx[i]), 8'(1 << skip_idx[i]), 4'(i));

        // FU backpressure holds issue, then entries 2 and 3 go in order.
        for (int i = 0; i < 3; i++)
            vec($sformatf("bp_hold%0d", i), 0, 0, 8'h0C, 0, 0, 8'h00, 0, 0, 0, 8'h00, 4'd6);
        vec("bp_go2", 0, 0, 8'h0C, 1, 0, 8'h00, 0, 1, 3'd2, 8'h04, 4'd6);
        vec("bp_go3", 0, 0, 8'h0C, 1, 0, 8'h00, 0, 1, 3'd3, 8'h08, 4'd7);

        // Refill, then drain 1..6 so rr_ptr=7 with occ=0x81.
        fill("fill_b", 8);
        for (int i = 0; i < 3; i++)
            vec($sformatf("drain_lo%0d", i), 0, 0, 8'h0E, 1, 0, 8'h00, (i == 0), 1,
                3'(i + 1), 8'(1 << (i + 1)), 4'(i));
        for (int i = 0; i < 3; i++)
            vec($sformatf("drain_hi%0d", i), 0, 0, 8'h70, 1, 0, 8'h00, 0, 1,
                3'(i + 4), 8'(1 << (i + 4)), 4'(i + 3));

        // Wrap-around: 7 then 0, leaving rr_ptr=1 which favours entry 1 next.
        vec("wrap7", 0, 0, 8'h81, 1, 0, 8'h00, 0, 1, 3'd7, 8'h80, 4'd6);
        vec("wrap0", 0, 0, 8'h81, 1, 0, 8'h00, 0, 1, 3'd0, 8'h01, 4'd7);
        fill("wrap_fill", 2);
        vec("wrap_rr1", 0, 0, 8'h03, 1, 0, 8'h00, 0, 1, 3'd1, 8'h02, 4'd6);
        vec("wrap_rr0", 0, 0, 8'h03, 1, 0, 8'h00, 0, 1, 3'd0, 8'h01, 4'd7);

        // Full array: issue and stalled dispatch together, the cleared slot is reused next cycle.
        fill("fill_c", 8);
        vec("full_issue", 0, 1, 8'h08, 1, 0, 8'h00, 1, 1, 3'd3, 8'h08, 4'd0);
        vec("full_reuse", 0, 1, 8'h00, 1, 0, 8'h08, 0, 0, 3'd0, 8'h00, 4'd1);

        // Drain 6 and 7 to reach occ=0x3F with rr_ptr=0.
        vec("pre_sq6", 0, 0, 8'hC0, 1, 0, 8'h00, 1, 1, 3'd6, 8'h40, 4'd0);
        vec("pre_sq7", 0, 0, 8'hC0, 1, 0, 8'h00, 0, 1, 3'd7, 8'h80, 4'd1);

        // Squash beats dispatch and issue; array comes back empty with rr_ptr=0.
        vec("squash", 0, 1, 8'h3F, 1, 1, 8'h00, 1, 0, 3'd0, 8'hFF, 4'd2);
        vec("post_sq0", 0, 1, 8'h00, 0, 0, 8'h01, 0, 0, 3'd0, 8'h00, 4'd8);
        vec("post_sq1", 0, 1, 8'h00, 0, 0, 8'h02, 0, 0, 3'd0, 8'h00, 4'd7);
        vec("post_sq_rr", 0, 0, 8'h03, 1, 0, 8'h00, 0, 1, 3'd0, 8'h01, 4'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
